// File: rtl/ysyx_22050499_icache_refill.sv
// ysyx_22050499_icache_refill
//
// AXI4 read-refill engine for the I-cache miss path. On a miss request it
// fetches the four consecutive 32-bit words starting at the word-aligned
// miss address and packs them into a 128-bit refill line. It then pulses
// refill_ok for one cycle, with refill_err reporting any bad beat.
//
// A line that would cross the AXI burst boundary is fetched as four
// single-beat reads (SPLIT mode). Any other line is fetched as one
// INCR burst of four beats (BURST mode).
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   req_valid, req_addr     : miss request level and miss address
//   refill_data             : packed line, word@addr in [127:96]
//   refill_ok, refill_err   : one-cycle completion pulse and error flag
//   ar* / r*                : AXI4 read address and read data channels
module ysyx_22050499_icache_refill #(
  parameter logic [3:0] AXI_ID        = 4'd0,
  parameter int         BOUNDARY_LOG2 = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [31:0]  req_addr,
  output logic [127:0] refill_data,
  output logic         refill_ok,
  output logic         refill_err,
  output logic         arvalid,
  input  logic         arready,
  output logic [31:0]  araddr,
  output logic [3:0]   arid,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  input  logic         rvalid,
  output logic         rready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic [3:0]   rid
);

  localparam int OW = BOUNDARY_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DONE, S_HOLD} state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   base;
  logic [1:0]    k;
  logic          err;
  logic          split;
  logic [31:0]   req_base;
  logic [OW-1:0] off_sum;
  logic          req_split;
  logic          beat;
  logic          beat_err;
  logic          rlast_exp;

  assign arid    = AXI_ID;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;

  // The line needs SPLIT mode when its last word (offset +12) lands past
  // the burst boundary, i.e. the in-boundary offset plus 12 carries out.
  always_comb begin
    req_base  = req_addr & ~32'h3;
    off_sum   = {1'b0, req_base[BOUNDARY_LOG2-1:0]} + OW'(12);
    req_split = off_sum[BOUNDARY_LOG2];
    beat      = rvalid && rready;
    rlast_exp = split || (k == 2'd3);
    beat_err  = (rresp != 2'b00) || (rid != AXI_ID) || (rlast != rlast_exp);
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Beats are counted by handshakes only. rlast is only checked, so a
  // wrong rlast cannot end a refill early.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = S_AR;
      S_AR:   if (arready) state_next = S_R;
      S_R: begin
        if (beat) begin
          if (k == 2'd3)  state_next = S_DONE;
          else if (split) state_next = S_AR;
        end
      end
      S_DONE: state_next = req_valid ? S_HOLD : S_IDLE;
      S_HOLD: if (!req_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and pulse outputs are registered from the next state, so
  // nothing combinational reaches a port from the AXI inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      refill_ok   <= 1'b0;
      refill_err  <= 1'b0;
      refill_data <= '0;
      araddr      <= '0;
      arlen       <= '0;
      base        <= '0;
      k           <= '0;
      err         <= 1'b0;
      split       <= 1'b0;
    end else begin
      arvalid   <= (state_next == S_AR);
      rready    <= (state_next == S_R);
      refill_ok <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base   <= req_base;
            split  <= req_split;
            k      <= 2'd0;
            err    <= 1'b0;
            araddr <= req_base;
            arlen  <= req_split ? 8'd0 : 8'd3;
          end
        end
        S_R: begin
          if (beat) begin
            // Slot k=0 is the top word of the line.
            refill_data[{~k, 5'b0} +: 32] <= rdata;
            k   <= k + 2'd1;
            err <= err | beat_err;
            if (k == 2'd3)
              refill_err <= err | beat_err;
            else if (split)
              araddr <= base + {28'd0, k + 2'd1, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050499_icache_refill.sv
// tb_ysyx_22050499_icache_refill
//
// Directed bench for the I-cache refill engine. A small AXI read slave
// lives in the do_refill task. All bench activity happens on the falling
// clock edge: the task observes the registered DUT outputs, then drives
// the inputs for the next rising edge.
module tb_ysyx_22050499_icache_refill;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] refill_data;
  logic         refill_ok;
  logic         refill_err;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic [3:0]   rid = '0;

  ysyx_22050499_icache_refill dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .refill_data(refill_data), .refill_ok(refill_ok), .refill_err(refill_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0]  beat_data [4];
  logic [31:0]  ar_addr_log [8];
  logic [7:0]   ar_len_log [8];
  int           n_ar;
  int           ok_count;
  int           ok_cycle;
  logic [127:0] ok_data;
  logic         ok_err;
  int           ar_unstable;
  int           ar_bad_attr;
  int           ar_after_ok;
  logic         timed_out;

  // Runs one refill against a scripted AXI slave. Each AR is held off for
  // ar_stall cycles and each beat is delayed by r_gap cycles. The beat at
  // index bad_beat gets SLVERR. After refill_ok, req_valid stays high for
  // hold_after more cycles. If reset_at_beat >= 0, reset is asserted as
  // soon as that many beats have been transferred. drop_early drops
  // req_valid right after the first AR handshake.
  task automatic do_refill(input logic [31:0] addr, input int ar_stall,
                           input int r_gap, input int bad_beat,
                           input int hold_after, input int reset_at_beat,
                           input bit drop_early);
    int stall_cnt = 0;
    int gap_cnt = 0;
    int pending = 0;
    int cyc = 0;
    int after_ok = 0;
    int beat_idx = 0;
    bit ar_wait = 0;
    bit done = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    n_ar = 0; ok_count = 0; ok_cycle = -1; ok_data = '0; ok_err = 1'b0;
    ar_unstable = 0; ar_bad_attr = 0; ar_after_ok = 0; timed_out = 1'b0;
    @(negedge clock);
    req_addr = addr; req_valid = 1'b1; arready = 1'b0; rvalid = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (refill_ok) begin
        ok_count++;
        if (ok_count == 1) begin
          ok_cycle = cyc; ok_data = refill_data; ok_err = refill_err;
        end
      end
      if (ok_count > 0 && arvalid) ar_after_ok++;
      if (ar_wait && (!arvalid || araddr !== prev_addr || arlen !== prev_len))
        ar_unstable++;
      ar_wait = 0;
      if (reset_at_beat >= 0 && beat_idx == reset_at_beat) begin
        reset = 1'b0; arready = 1'b0; rvalid = 1'b0; done = 1;
      end else begin
        arready = 1'b0;
        if (arvalid && ok_count == 0) begin
          if (stall_cnt < ar_stall) begin
            stall_cnt++; ar_wait = 1; prev_addr = araddr; prev_len = arlen;
          end else begin
            arready = 1'b1;
            if (n_ar < 8) begin
              ar_addr_log[n_ar] = araddr; ar_len_log[n_ar] = arlen;
            end
            if (arsize !== 3'd2 || arburst !== 2'b01 || arid !== 4'd0)
              ar_bad_attr++;
            n_ar++;
            pending += int'(arlen) + 1;
            stall_cnt = 0;
            if (drop_early) req_valid = 1'b0;
          end
        end
        rvalid = 1'b0;
        if (rready && pending > 0 && beat_idx < 4) begin
          if (gap_cnt < r_gap) gap_cnt++;
          else begin
            rvalid = 1'b1;
            rdata  = beat_data[beat_idx];
            rresp  = (beat_idx == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (pending == 1);
            rid    = 4'd0;
            pending--; beat_idx++; gap_cnt = 0;
          end
        end
        if (ok_count > 0) begin
          if (after_ok >= hold_after) req_valid = 1'b0;
          after_ok++;
          if (after_ok > hold_after + 2) done = 1;
        end
      end
    end
    if (!done) timed_out = 1'b1;
    arready = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_arvalid got %0b expected 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rready got %0b expected 0", rready); end
    checks++; if (refill_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok got %0b expected 0", refill_ok); end
    checks++; if (refill_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b expected 0", refill_err); end
    checks++; if (araddr !== 32'h0 || arlen !== 8'h0) begin errors++; $display("[TB] FAIL reset_ar got %h/%h expected 0/0", araddr, arlen); end
    checks++; if (refill_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_data got %h expected 0", refill_data); end
    checks++; if (arsize !== 3'd2 || arburst !== 2'd1 || arid !== 4'd0) begin errors++; $display("[TB] FAIL ar_const got %0d/%0d/%0d expected 2/1/0", arsize, arburst, arid); end
    reset = 1'b1;
  endtask

  task automatic test_burst();
    beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
    beat_data[2] = 32'h33333333; beat_data[3] = 32'h44444444;
    do_refill(32'h3000_0010, 0, 0, -1, 0, -1, 0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL burst_timeout got %0b expected 0", timed_out); end
    checks++; if (n_ar !== 1) begin errors++; $display("[TB] FAIL burst_n_ar got %0d expected 1", n_ar); end
    checks++; if (ar_addr_log[0] !== 32'h3000_0010 || ar_len_log[0] !== 8'd3) begin errors++; $display("[TB] FAIL burst_ar got %h/%0d expected 30000010/3", ar_addr_log[0], ar_len_log[0]); end
    checks++; if (ar_bad_attr !== 0) begin errors++; $display("[TB] FAIL burst_attr got %0d expected 0", ar_bad_attr); end
    checks++; if (ok_count !== 1) begin errors++; $display("[TB] FAIL burst_ok_count got %0d expected 1", ok_count); end
    // Accept edge, AR edge, four beat edges, then the pulse cycle.
    checks++; if (ok_cycle !== 6) begin errors++; $display("[TB] FAIL burst_latency got %0d expected 6", ok_cycle); end
    checks++; if (ok_data !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("[TB] FAIL burst_data got %h expected 11111111222222223333333344444444", ok_data); end
    checks++; if (ok_err !== 1'b0) begin errors++; $display("[TB] FAIL burst_err got %0b expected 0", ok_err); end
    checks++; if (refill_data !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("[TB] FAIL burst_data_hold got %h expected 11111111222222223333333344444444", refill_data); end
  endtask

  task automatic test_backpressure();
    do_refill(32'h3000_0010, 3, 2, -1, 0, -1, 0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout got %0b expected 0", timed_out); end
    checks++; if (ar_unstable !== 0) begin errors++; $display("[TB] FAIL bp_ar_stable got %0d expected 0", ar_unstable); end
    checks++; if (n_ar !== 1) begin errors++; $display("[TB] FAIL bp_n_ar got %0d expected 1", n_ar); end
    checks++; if (ok_count !== 1) begin errors++; $display("[TB] FAIL bp_ok_count got %0d expected 1", ok_count); end
    checks++; if (ok_data !== 128'h11111111_22222222_33333333_44444444 || ok_err !== 1'b0) begin errors++; $display("[TB] FAIL bp_data got %h/%0b expected 11111111222222223333333344444444/0", ok_data, ok_err); end
  endtask

  task automatic test_crossing();
    beat_data[0] = 32'hA0A0A0A1; beat_data[1] = 32'hB0B0B0B2;
    beat_data[2] = 32'hC0C0C0C3; beat_data[3] = 32'hD0D0D0D4;
    do_refill(32'h3000_0FF8, 0, 0, -1, 0, -1, 0);
    checks++; if (timed_out !== 1'b0 || n_ar !== 4) begin errors++; $display("[TB] FAIL cross_n_ar got %0d (timeout %0b) expected 4", n_ar, timed_out); end
    checks++; if (ar_addr_log[0] !== 32'h3000_0FF8 || ar_addr_log[1] !== 32'h3000_0FFC || ar_addr_log[2] !== 32'h3000_1000 || ar_addr_log[3] !== 32'h3000_1004) begin errors++; $display("[TB] FAIL cross_addr got %h %h %h %h expected 30000ff8 30000ffc 30001000 30001004", ar_addr_log[0], ar_addr_log[1], ar_addr_log[2], ar_addr_log[3]); end
    checks++; if (ar_len_log[0] !== 8'd0 || ar_len_log[1] !== 8'd0 || ar_len_log[2] !== 8'd0 || ar_len_log[3] !== 8'd0) begin errors++; $display("[TB] FAIL cross_len got %0d %0d %0d %0d expected 0 0 0 0", ar_len_log[0], ar_len_log[1], ar_len_log[2], ar_len_log[3]); end
    checks++; if (ok_data !== 128'hA0A0A0A1_B0B0B0B2_C0C0C0C3_D0D0D0D4 || ok_err !== 1'b0) begin errors++; $display("[TB] FAIL cross_data got %h/%0b expected a0a0a0a1b0b0b0b2c0c0c0c3d0d0d0d4/0", ok_data, ok_err); end
    // Accept edge, four AR+beat pairs, then the pulse cycle.
    checks++; if (ok_cycle !== 9) begin errors++; $display("[TB] FAIL cross_latency got %0d expected 9", ok_cycle); end
    // Last line that still fits in the 4 KB page stays a single burst.
    do_refill(32'h3000_0FF0, 0, 0, -1, 0, -1, 0);
    checks++; if (n_ar !== 1 || ar_len_log[0] !== 8'd3 || ar_addr_log[0] !== 32'h3000_0FF0) begin errors++; $display("[TB] FAIL edge_burst got %0d/%0d/%h expected 1/3/30000ff0", n_ar, ar_len_log[0], ar_addr_log[0]); end
    // Top of memory wraps to address 0.
    do_refill(32'hFFFF_FFF8, 0, 0, -1, 0, -1, 0);
    checks++; if (n_ar !== 4 || ar_addr_log[2] !== 32'h0 || ar_addr_log[3] !== 32'h4) begin errors++; $display("[TB] FAIL wrap_addr got %0d/%h/%h expected 4/00000000/00000004", n_ar, ar_addr_log[2], ar_addr_log[3]); end
  endtask

  task automatic test_error();
    beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
    beat_data[2] = 32'h33333333; beat_data[3] = 32'h44444444;
    do_refill(32'h3000_0040, 0, 0, 2, 0, -1, 0);
    checks++; if (ok_count !== 1 || ok_err !== 1'b1) begin errors++; $display("[TB] FAIL err_flag got %0d/%0b expected 1/1", ok_count, ok_err); end
    checks++; if (ok_data !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("[TB] FAIL err_data got %h expected 11111111222222223333333344444444", ok_data); end
    checks++; if (refill_err !== 1'b1) begin errors++; $display("[TB] FAIL err_hold got %0b expected 1", refill_err); end
    do_refill(32'h3000_0040, 0, 0, -1, 0, -1, 0);
    checks++; if (ok_count !== 1 || ok_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %0d/%0b expected 1/0", ok_count, ok_err); end
  endtask

  task automatic test_level_hold();
    do_refill(32'h3000_0080, 0, 0, -1, 5, -1, 0);
    checks++; if (ok_count !== 1 || ar_after_ok !== 0) begin errors++; $display("[TB] FAIL hold_no_rearm got %0d/%0d expected 1/0", ok_count, ar_after_ok); end
    // Unaligned address: low bits ignored.
    do_refill(32'h3000_0023, 0, 0, -1, 0, -1, 0);
    checks++; if (ok_count !== 1 || n_ar !== 1 || ar_addr_log[0] !== 32'h3000_0020) begin errors++; $display("[TB] FAIL hold_restart got %0d/%0d/%h expected 1/1/30000020", ok_count, n_ar, ar_addr_log[0]); end
  endtask

  task automatic test_drop_mid();
    do_refill(32'h3000_0100, 0, 1, -1, 0, -1, 1);
    checks++; if (timed_out !== 1'b0 || ok_count !== 1) begin errors++; $display("[TB] FAIL drop_ok got %0d (timeout %0b) expected 1", ok_count, timed_out); end
    checks++; if (ok_data !== 128'h11111111_22222222_33333333_44444444) begin errors++; $display("[TB] FAIL drop_data got %h expected 11111111222222223333333344444444", ok_data); end
  endtask

  task automatic test_reset_mid();
    do_refill(32'h3000_0200, 0, 0, -1, 0, 2, 0);
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || refill_ok !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl got %0b%0b%0b expected 000", arvalid, rready, refill_ok); end
    checks++; if (refill_data !== 128'h0 || araddr !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_data got %h/%h expected 0/0", refill_data, araddr); end
    reset = 1'b1;
    do_refill(32'h3000_0300, 0, 0, -1, 0, -1, 0);
    checks++; if (ok_count !== 1 || ok_data !== 128'h11111111_22222222_33333333_44444444 || ok_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after got %0d/%h/%0b expected 1/11111111222222223333333344444444/0", ok_count, ok_data, ok_err); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_crossing();
    test_error();
    test_level_hold();
    test_drop_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

endmodule
